// File: rtl/ifetch_pkg.sv
// Shared fetch-side types and line layout for the instruction cache.
// Exports cacheState, line/word widths and the word-select helper.
package ifetch_pkg;

  localparam int LINE_WIDTH  = 64;
  localparam int WORD_WIDTH  = 32;
  localparam int HI_WORD_LSB = 32;
  localparam int LO_WORD_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2
  } cacheState;

  // offset 0 selects the upper word of the line
  function automatic logic [WORD_WIDTH-1:0] select_word(
    input logic [LINE_WIDTH-1:0] line,
    input logic                  offset
  );
    return offset ? line[LO_WORD_LSB +: WORD_WIDTH]
                  : line[HI_WORD_LSB +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/instruction_cache_controller_if.sv
// Fetch-side and memory-side bus of the instruction cache.
// master: fetch/memory environment; slave: the cache controller.
interface instruction_cache_controller_if;

  logic [31:0] fetchPC;
  logic        fetchValid;
  logic        flush;
  logic [31:0] instruction;
  logic        instructionValid;
  logic        stallFetch;
  logic        memRequest;
  logic [31:0] memPC;
  logic [63:0] memLineData;
  logic        memReceived;
  logic [15:0] missCount;

  modport master (
    output fetchPC, fetchValid, flush,
    output memLineData, memReceived,
    input  instruction, instructionValid, stallFetch,
    input  memRequest, memPC, missCount
  );

  modport slave (
    input  fetchPC, fetchValid, flush,
    input  memLineData, memReceived,
    output instruction, instructionValid, stallFetch,
    output memRequest, memPC, missCount
  );

endinterface

// File: rtl/cache_line_array.sv
// Valid/tag/data storage: async read by index, sync write,
// sync clear-all and async reset of the valid bits.
module cache_line_array
  import ifetch_pkg::*;
#(
  parameter int numLines   = 8,
  parameter int indexWidth = 3,
  parameter int tagWidth   = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [indexWidth-1:0] rd_index,
  output logic                  rd_valid,
  output logic [tagWidth-1:0]   rd_tag,
  output logic [LINE_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [indexWidth-1:0] wr_index,
  input  logic [tagWidth-1:0]   wr_tag,
  input  logic [LINE_WIDTH-1:0] wr_data,
  input  logic                  clear
);

  logic [numLines-1:0]   valid;
  logic [tagWidth-1:0]   tags  [numLines];
  logic [LINE_WIDTH-1:0] lines [numLines];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = lines[rd_index];

endmodule

// File: rtl/instruction_cache_controller.sv
// Direct-mapped I-cache with single-refill sequencer.
// Ports: clk, reset (async, active-low), bus (slave modport).
module instruction_cache_controller
  import ifetch_pkg::*;
#(
  parameter int numLines       = 8,
  parameter int missCountWidth = 16
) (
  input logic                           clk,
  input logic                           reset,
  instruction_cache_controller_if.slave bus
);

  localparam int IB = $clog2(numLines);
  localparam int TW = 29 - IB;

  cacheState state;
  cacheState state_n;

  // missPC without its always-zero low three bits
  logic [28:0]               miss_line;
  logic                      discard;
  logic [missCountWidth-1:0] miss_cnt;

  logic [IB-1:0]         rd_index;
  logic [TW-1:0]         fetch_tag;
  logic                  rd_valid;
  logic [TW-1:0]         rd_tag;
  logic [LINE_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic                  hit;
  logic                  stall;

  assign rd_index  = bus.fetchPC[3 +: IB];
  assign fetch_tag = bus.fetchPC[31 -: TW];

  // a flush arriving with the line drops it as well
  assign wr_en = (state == WAIT) && bus.memReceived
               && !discard && !bus.flush;

  cache_line_array #(
    .numLines  (numLines),
    .indexWidth(IB),
    .tagWidth  (TW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_index(rd_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_index(miss_line[IB-1:0]),
    .wr_tag  (miss_line[28 -: TW]),
    .wr_data (bus.memLineData),
    .clear   (bus.flush)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    hit     = (state == IDLE) && bus.fetchValid
            && rd_valid && (rd_tag == fetch_tag);
    unique case (state)
      IDLE: begin
        if (bus.fetchValid && !hit) begin
          state_n = REQUEST;
          stall   = 1'b1;
        end
      end
      REQUEST: begin
        state_n = WAIT;
        stall   = 1'b1;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.memReceived) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_line <= '0;
      discard   <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      if (state == IDLE && state_n == REQUEST) begin
        miss_line <= bus.fetchPC[31:3];
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
      if (state == WAIT && bus.memReceived) begin
        discard <= 1'b0;
      end else if (bus.flush && state != IDLE) begin
        discard <= 1'b1;
      end
    end
  end

  // outputs forced quiet while reset is held
  assign bus.instructionValid = reset && hit;
  assign bus.instruction = (reset && hit)
    ? select_word(rd_data, bus.fetchPC[2]) : '0;
  assign bus.stallFetch = reset && stall;
  assign bus.memRequest = reset && (state == REQUEST);
  assign bus.memPC      = {miss_line, 3'b000};
  assign bus.missCount  = 16'(miss_cnt);

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed self-checking bench for instruction_cache_controller.
// missCount built 4 bits wide so saturation is reachable quickly.
module tb_instruction_cache_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total = 0;

  localparam logic [63:0] L0   = {32'h00500113, 32'h00300193};
  localparam logic [63:0] L40  = {32'h00a00093, 32'h00b00113};
  localparam logic [63:0] L8   = {32'h003100b3, 32'h00000013};
  localparam logic [63:0] L10  = {32'h00108093, 32'h00000073};
  localparam logic [63:0] JUNK = 64'hdeadbeef_cafef00d;

  instruction_cache_controller_if bus();

  instruction_cache_controller #(
    .numLines      (8),
    .missCountWidth(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.fetchPC    = a;
    bus.fetchValid = 1'b1;
    #1;
  endtask

  // from the IDLE miss cycle through to the replay cycle
  task automatic do_miss(input logic [31:0] a,
                         input logic [63:0] line);
    tick();
    chk("req_pulse", bus.memRequest, 1);
    chk("req_pc", bus.memPC, a & 32'hffff_fff8);
    tick();
    chk("wait_noreq", bus.memRequest, 0);
    chk("wait_stall", bus.stallFetch, 1);
    bus.memReceived = 1'b1;
    bus.memLineData = line;
    tick();
    bus.memReceived = 1'b0;
    bus.memLineData = '0;
    #1;
  endtask

  initial begin
    bus.fetchPC     = '0;
    bus.fetchValid  = 1'b0;
    bus.flush       = 1'b0;
    bus.memLineData = '0;
    bus.memReceived = 1'b0;
    #12;
    chk("rst_req", bus.memRequest, 0);
    chk("rst_iv", bus.instructionValid, 0);
    chk("rst_instr", bus.instruction, 0);
    chk("rst_stall", bus.stallFetch, 0);
    chk("rst_cnt", bus.missCount, 0);
    chk("rst_pc", bus.memPC, 0);
    tick();
    reset = 1'b1;
    tick();

    // cold miss at 0x0
    fetch(32'h0);
    chk("c0_stall", bus.stallFetch, 1);
    chk("c0_iv", bus.instructionValid, 0);
    do_miss(32'h0, L0);
    chk("c3_iv", bus.instructionValid, 1);
    chk("c3_instr", bus.instruction, 32'h00500113);
    chk("c3_stall", bus.stallFetch, 0);
    chk("c3_cnt", bus.missCount, 1);

    // same-line hit on the other word
    fetch(32'h4);
    chk("hit4_instr", bus.instruction, 32'h00300193);
    chk("hit4_stall", bus.stallFetch, 0);
    chk("hit4_iv", bus.instructionValid, 1);
    tick();
    chk("hit4_noreq", bus.memRequest, 0);

    // conflict at index 0
    fetch(32'h40);
    chk("c40_stall", bus.stallFetch, 1);
    do_miss(32'h40, L40);
    chk("c40_instr", bus.instruction, 32'h00a00093);
    fetch(32'h0);
    chk("re0_stall", bus.stallFetch, 1);
    do_miss(32'h0, L0);
    chk("re0_instr", bus.instruction, 32'h00500113);
    chk("re0_cnt", bus.missCount, 3);

    // flush during WAIT drops the line
    fetch(32'h8);
    chk("c8_stall", bus.stallFetch, 1);
    tick();
    chk("c8_req", bus.memRequest, 1);
    tick();
    bus.flush       = 1'b1;
    bus.memReceived = 1'b1;
    bus.memLineData = JUNK;
    tick();
    bus.flush       = 1'b0;
    bus.memReceived = 1'b0;
    #1;
    chk("c8_remiss", bus.stallFetch, 1);
    chk("c8_noiv", bus.instructionValid, 0);
    do_miss(32'h8, L8);
    chk("c8_instr", bus.instruction, 32'h003100b3);
    chk("c8_cnt", bus.missCount, 5);
    fetch(32'h0);
    chk("flushed0", bus.stallFetch, 1);
    bus.fetchValid = 1'b0;
    tick();
    tick();
    tick();

    // flush during REQUEST sets discard
    fetch(32'h10);
    chk("c10_stall", bus.stallFetch, 1);
    tick();
    chk("c10_req", bus.memRequest, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush       = 1'b0;
    bus.memReceived = 1'b1;
    bus.memLineData = JUNK;
    tick();
    bus.memReceived = 1'b0;
    #1;
    chk("c10_remiss", bus.stallFetch, 1);
    do_miss(32'h10, L10);
    chk("c10_instr", bus.instruction, 32'h00108093);

    // reset pulsed in REQUEST
    fetch(32'h20);
    tick();
    chk("c20_req", bus.memRequest, 1);
    reset = 1'b0;
    bus.fetchValid = 1'b0;
    #1;
    chk("mid_rst_req", bus.memRequest, 0);
    chk("mid_rst_stall", bus.stallFetch, 0);
    chk("mid_rst_cnt", bus.missCount, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_req", bus.memRequest, 0);
    tick();
    chk("post_rst_req2", bus.memRequest, 0);
    fetch(32'h0);
    chk("post_rst_miss", bus.stallFetch, 1);
    do_miss(32'h0, L0);
    chk("post_rst_instr", bus.instruction, 32'h00500113);
    chk("post_rst_cnt", bus.missCount, 1);

    // saturation of the 4-bit counter
    for (int i = 0; i < 14; i++) begin
      fetch((i % 2 == 0) ? 32'h40 : 32'h0);
      do_miss((i % 2 == 0) ? 32'h40 : 32'h0,
              (i % 2 == 0) ? L40 : L0);
    end
    chk("sat_reach", bus.missCount, 15);
    fetch(32'h40);
    chk("sat_miss", bus.stallFetch, 1);
    do_miss(32'h40, L40);
    chk("sat_hold", bus.missCount, 15);
    chk("sat_instr", bus.instruction, 32'h00a00093);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
